// File: rtl/shreg_univ_if.sv
// Bus for shreg_univ: mode/enable/data inputs and register, serial-out, counter and DONE outputs.
// The CLR signal exists only when SHREG_UNIV_SYNC_CLR_EN is defined.
interface shreg_univ_if #(
   parameter int WIDTH = 8
);
   localparam int CW = $clog2(WIDTH);

   logic             EN;
   logic [1:0]       M;
   logic             SL;
   logic             SR;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] Q;
   logic             SO_L;
   logic             SO_R;
   logic [CW-1:0]    CNT;
   logic             DONE;
`ifdef SHREG_UNIV_SYNC_CLR_EN
   logic             CLR;

   modport master (
      output EN, M, SL, SR, D, CLR,
      input  Q, SO_L, SO_R, CNT, DONE
   );

   modport slave (
      input  EN, M, SL, SR, D, CLR,
      output Q, SO_L, SO_R, CNT, DONE
   );
`else
   modport master (
      output EN, M, SL, SR, D,
      input  Q, SO_L, SO_R, CNT, DONE
   );

   modport slave (
      input  EN, M, SL, SR, D,
      output Q, SO_L, SO_R, CNT, DONE
   );
`endif
endinterface

// File: rtl/shreg_univ.sv
// WIDTH-bit universal register (hold / shift left / shift right / load) with a shift counter
// that pulses DONE after every WIDTH shifts. Optional synchronous clear: SHREG_UNIV_SYNC_CLR_EN.
module shreg_univ #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic        C,
   input  logic        R,
   shreg_univ_if.slave bus
);
   // Derived from WIDTH only, so it cannot be overridden from outside.
   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_LEFT  = 2'b01;
   localparam logic [1:0] MODE_RIGHT = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] q;
   logic [CW-1:0]    cnt;
   logic             done;

   logic [CW-1:0]    cnt_step;
   logic             cnt_wrap;

   // Every shift advances the count; the WIDTH-th wraps to 0 so unused codes stay unreachable.
   always_comb begin
      cnt_wrap = (cnt == CNT_LAST);
      cnt_step = cnt_wrap ? '0 : cnt + CW'(1);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge C or negedge R) begin
      if (!R) begin
         q    <= RESET_VAL;
         cnt  <= '0;
         done <= 1'b0;
`ifdef SHREG_UNIV_SYNC_CLR_EN
      end else if (bus.CLR) begin
         q    <= RESET_VAL;
         cnt  <= '0;
         done <= 1'b0;
`endif
      end else if (!bus.EN) begin
         done <= 1'b0;
      end else begin
         case (bus.M)
            MODE_HOLD: begin
               done <= 1'b0;
            end
            MODE_LEFT: begin
               q    <= {q[WIDTH-2:0], bus.SL};
               cnt  <= cnt_step;
               done <= cnt_wrap;
            end
            MODE_RIGHT: begin
               q    <= {bus.SR, q[WIDTH-1:1]};
               cnt  <= cnt_step;
               done <= cnt_wrap;
            end
            MODE_LOAD: begin
               q    <= bus.D;
               cnt  <= '0;
               done <= 1'b0;
            end
         endcase
      end
   end

   assign bus.Q    = q;
   assign bus.CNT  = cnt;
   assign bus.DONE = done;
   assign bus.SO_L = q[WIDTH-1];
   assign bus.SO_R = q[0];
endmodule
